// File: rtl/tfb_pkg.sv
// Shared definitions for the text frame buffer: command codes, fill-engine states, cell type.
package tfb_pkg;

  localparam logic [1:0] TFB_CMD_NOP       = 2'd0;
  localparam logic [1:0] TFB_CMD_CLEAR_ALL = 2'd1;
  localparam logic [1:0] TFB_CMD_SCROLL_UP = 2'd2;
  localparam logic [1:0] TFB_CMD_CLEAR_ROW = 2'd3;

  typedef enum logic [0:0] {StIdle, StFill} tfb_state_e;

  localparam int unsigned TFB_CELL_W = 32;
  typedef logic [TFB_CELL_W-1:0] tfb_cell_t;

endpackage

// File: rtl/tfb_ram.sv
// Simple dual-port cell RAM: one write port, one registered read port, read-before-write.
module tfb_ram #(
  parameter int unsigned DEPTH = 2400,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             iClk,
  input  logic             iWe,
  input  logic [AW-1:0]    iWAddr,
  input  logic [WIDTH-1:0] iWData,
  input  logic [AW-1:0]    iRAddr,
  output logic [WIDTH-1:0] oRData
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iWAddr] <= iWData;
    end
    rdata_q <= mem_q[iRAddr];
  end

  assign oRData = rdata_q;

endmodule

// File: rtl/text_frame_buffer.sv
// Character-cell frame buffer with fill engine (clear/scroll) and wrap-around base row.
// Optional cursor blink overlay enabled by the TFB_CURSOR_EN macro.
module text_frame_buffer
  import tfb_pkg::*;
#(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned CELL_W    = 32,
  parameter int unsigned COL_W     = $clog2(COLS),
  parameter int unsigned ROW_W     = $clog2(ROWS),
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iWValid,
  output logic              oWReady,
  input  logic [ROW_W-1:0]  iWRow,
  input  logic [COL_W-1:0]  iWCol,
  input  logic [CELL_W-1:0] iWData,
  input  logic              iCmdValid,
  input  logic [1:0]        iCmd,
  input  logic [ROW_W-1:0]  iCmdRow,
  input  logic [CELL_W-1:0] iFillData,
  output logic              oCmdReady,
  input  logic [ROW_W-1:0]  iRRow,
  input  logic [COL_W-1:0]  iRCol,
  output logic [CELL_W-1:0] oRData,
  output logic              oBusy,
  output logic [ROW_W-1:0]  oBaseRow,
  input  logic [ROW_W-1:0]  iCurRow,
  input  logic [COL_W-1:0]  iCurCol,
  output logic              oCurHit
);

  localparam int unsigned Depth = ROWS * COLS;
  localparam int unsigned AW    = $clog2(Depth);
  localparam logic [ROW_W:0]   RowsW   = ROWS[ROW_W:0];
  localparam logic [COL_W:0]   ColsW   = COLS[COL_W:0];
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);

  tfb_state_e        state_q, state_d;
  logic [ROW_W-1:0]  base_q, base_d;
  logic [AW-1:0]     fill_addr_q, fill_addr_d;
  logic [AW-1:0]     fill_end_q, fill_end_d;
  logic [CELL_W-1:0] fill_data_q, fill_data_d;
  logic              rd_ok_q, rd_ok_d;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [CELL_W-1:0] ram_wdata;
  logic [AW-1:0]     ram_raddr;
  logic [CELL_W-1:0] ram_rdata;
  logic              ready;
  logic              w_in_range;
  logic [AW-1:0]     row_start;

  // Logical-to-physical row: one conditional subtract, no divider.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                input logic [ROW_W-1:0] base);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, base};
    if (sum >= RowsW) sum = sum - RowsW;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                              input logic [COL_W-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  always_comb begin
    ready      = (state_q == StIdle) && !iRst;
    w_in_range = ({1'b0, iWRow} < RowsW) && ({1'b0, iWCol} < ColsW);
    rd_ok_d    = ({1'b0, iRRow} < RowsW) && ({1'b0, iRCol} < ColsW);
    ram_raddr  = cell_addr(phys_row(iRRow, base_q), iRCol);
    row_start  = '0;

    state_d     = state_q;
    base_d      = base_q;
    fill_addr_d = fill_addr_q;
    fill_end_d  = fill_end_q;
    fill_data_d = fill_data_q;
    ram_we      = 1'b0;
    ram_waddr   = cell_addr(phys_row(iWRow, base_q), iWCol);
    ram_wdata   = iWData;

    unique case (state_q)
      StIdle: begin
        ram_we = ready && iWValid && w_in_range;
        if (ready && iCmdValid) begin
          case (iCmd)
            TFB_CMD_CLEAR_ALL: begin
              base_d      = '0;
              fill_addr_d = '0;
              fill_end_d  = AW'(Depth - 1);
              fill_data_d = iFillData;
              state_d     = StFill;
            end
            TFB_CMD_SCROLL_UP: begin
              // The old top row becomes the new bottom row, so only it needs blanking.
              row_start   = cell_addr(base_q, '0);
              base_d      = (base_q == LastRow) ? '0 : base_q + 1'b1;
              fill_addr_d = row_start;
              fill_end_d  = row_start + AW'(COLS - 1);
              fill_data_d = iFillData;
              state_d     = StFill;
            end
            TFB_CMD_CLEAR_ROW: begin
              if ({1'b0, iCmdRow} < RowsW) begin
                row_start   = cell_addr(phys_row(iCmdRow, base_q), '0);
                fill_addr_d = row_start;
                fill_end_d  = row_start + AW'(COLS - 1);
                fill_data_d = iFillData;
                state_d     = StFill;
              end
            end
            default: ;
          endcase
        end
      end
      StFill: begin
        ram_we    = 1'b1;
        ram_waddr = fill_addr_q;
        ram_wdata = fill_data_q;
        if (fill_addr_q == fill_end_q) begin
          state_d = StIdle;
        end else begin
          fill_addr_d = fill_addr_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      fill_addr_q <= '0;
      fill_end_q  <= '0;
      fill_data_q <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      fill_addr_q <= fill_addr_d;
      fill_end_q  <= fill_end_d;
      fill_data_q <= fill_data_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  tfb_ram #(
    .DEPTH (Depth),
    .WIDTH (CELL_W),
    .AW    (AW)
  ) u_ram (
    .iClk   (iClk),
    .iWe    (ram_we),
    .iWAddr (ram_waddr),
    .iWData (ram_wdata),
    .iRAddr (ram_raddr),
    .oRData (ram_rdata)
  );

  assign oRData    = rd_ok_q ? ram_rdata : '0;
  assign oWReady   = ready;
  assign oCmdReady = ready;
  assign oBusy     = (state_q == StFill) && !iRst;
  assign oBaseRow  = base_q;

`ifdef TFB_CURSOR_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        cur_hit_q, cur_hit_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_DIV - 1) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    cur_hit_d = (iRRow == iCurRow) && (iRCol == iCurCol) && blink_q;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      cur_hit_q   <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      cur_hit_q   <= cur_hit_d;
    end
  end

  assign oCurHit = cur_hit_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^{iCurRow, iCurCol, BLINK_DIV[0]};
  assign oCurHit       = 1'b0;
`endif

endmodule

// File: tb/tb_text_frame_buffer.sv
// Self-checking bench for text_frame_buffer against a logical-screen reference model.
module tb_text_frame_buffer;

  localparam int unsigned ROWS = 30;
  localparam int unsigned COLS = 80;
  localparam int unsigned CW   = 32;
`ifdef TFB_CURSOR_EN
  localparam int unsigned BD = 4;
`else
  localparam int unsigned BD = 25000000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [4:0]    w_row = '0;
  logic [6:0]    w_col = '0;
  logic [CW-1:0] w_data = '0;
  logic          c_valid = 1'b0;
  logic [1:0]    c_cmd = '0;
  logic [4:0]    c_row = '0;
  logic [CW-1:0] c_fill = '0;
  logic          c_ready;
  logic [4:0]    r_row = '0;
  logic [6:0]    r_col = '0;
  logic [CW-1:0] r_data;
  logic          busy;
  logic [4:0]    base_row;
  logic [4:0]    cur_row = '0;
  logic [6:0]    cur_col = '0;
  logic          cur_hit;

  text_frame_buffer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CELL_W    (CW),
    .BLINK_DIV (BD)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iWValid   (w_valid),
    .oWReady   (w_ready),
    .iWRow     (w_row),
    .iWCol     (w_col),
    .iWData    (w_data),
    .iCmdValid (c_valid),
    .iCmd      (c_cmd),
    .iCmdRow   (c_row),
    .iFillData (c_fill),
    .oCmdReady (c_ready),
    .iRRow     (r_row),
    .iRCol     (r_col),
    .oRData    (r_data),
    .oBusy     (busy),
    .oBaseRow  (base_row),
    .iCurRow   (cur_row),
    .iCurCol   (cur_col),
    .oCurHit   (cur_hit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: the screen as the display sees it (logical rows), plus a scroll count.
  logic [CW-1:0] model [ROWS][COLS];
  int            base_m = 0;

  typedef struct {
    bit          wr;
    int          row;
    int          col;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input int r, input int c);
    if (r < ROWS && c < COLS) return model[r][c];
    return 32'h0;
  endfunction

  function automatic int exp_busy(input int cmd, input int row);
    case (cmd)
      1: return ROWS * COLS;
      2: return COLS;
      3: return (row < ROWS) ? COLS : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_write(input int r, input int c, input logic [31:0] d);
    if (r < ROWS && c < COLS) model[r][c] = d;
  endtask

  task automatic model_cmd(input int cmd, input int row, input logic [31:0] fill);
    case (cmd)
      1: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) model[r][c] = fill;
        base_m = 0;
      end
      2: begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++) model[r][c] = model[r+1][c];
        for (int c = 0; c < COLS; c++) model[ROWS-1][c] = fill;
        base_m = (base_m + 1) % ROWS;
      end
      3: begin
        if (row < ROWS)
          for (int c = 0; c < COLS; c++) model[row][c] = fill;
      end
      default: ;
    endcase
  endtask

  // Waits out the fill engine (bounded) and checks its duration and the ready gating.
  task automatic wait_fill(input string name, input int exp_n);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (w_ready !== 1'b0 || c_ready !== 1'b0) bad++;
      tick();
      n++;
    end
    chk({name, "_busy_cycles"}, n, exp_n);
    chk({name, "_ready_low"}, bad, 0);
    chk({name, "_ready_after"}, w_ready, 1'b1);
    chk({name, "_base"}, base_row, base_m);
  endtask

  task automatic issue_cmd(input string name, input int cmd, input int row,
                           input logic [31:0] fill);
    c_valid = 1'b1;
    c_cmd   = 2'(cmd);
    c_row   = 5'(row);
    c_fill  = fill;
    chk({name, "_cmd_ready"}, c_ready, 1'b1);
    tick();
    c_valid = 1'b0;
    model_cmd(cmd, row, fill);
    wait_fill(name, exp_busy(cmd, row));
  endtask

  task automatic do_write(input int r, input int c, input logic [31:0] d);
    w_valid = 1'b1;
    w_row   = 5'(r);
    w_col   = 7'(c);
    w_data  = d;
    tick();
    w_valid = 1'b0;
    model_write(r, c, d);
  endtask

  task automatic do_read(input string name, input int r, input int c, input logic [31:0] exp);
    r_row = 5'(r);
    r_col = 7'(c);
    tick();
    chk(name, r_data, exp);
  endtask

  task automatic check_screen(input string name);
    int bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        r_row = 5'(r);
        r_col = 7'(c);
        tick();
        if (r_data !== model[r][c]) bad++;
      end
    end
    chk(name, bad, 0);
  endtask

  initial begin
    int wv, wr, wc, rr, rc, cv, cmd, crow;
    logic [31:0] wd, fill, exp;
    int trans, last_t, hits;
    logic prev;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_wready", w_ready, 1'b0);
    chk("rst_cmdready", c_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", r_data, 32'h0);
    chk("rst_base", base_row, 32'h0);
    chk("rst_curhit", cur_hit, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_wready", w_ready, 1'b1);

    // Write/read vectors, including out-of-range coordinates
    vt[0] = '{1'b1, 0, 1,   32'hFFFFFF48, 32'h0};
    vt[1] = '{1'b0, 0, 1,   32'h0,        32'hFFFFFF48};
    vt[2] = '{1'b0, 0, 80,  32'h0,        32'h0};
    vt[3] = '{1'b1, 1, 0,   32'h12345678, 32'h0};
    vt[4] = '{1'b1, 0, 80,  32'hDEADBEEF, 32'h0};
    vt[5] = '{1'b0, 1, 0,   32'h0,        32'h12345678};
    vt[6] = '{1'b1, 29, 79, 32'h0BADF00D, 32'h0};
    vt[7] = '{1'b0, 29, 79, 32'h0,        32'h0BADF00D};
    vt[8] = '{1'b0, 31, 127, 32'h0,       32'h0};
    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) do_write(vt[i].row, vt[i].col, vt[i].data);
      else do_read($sformatf("vec%0d_rd", i), vt[i].row, vt[i].col, vt[i].exp);
    end

    // Clear screen
    issue_cmd("clear_all", 1, 0, 32'h00000020);
    check_screen("clear_all_screen");

    // Scroll once
    do_write(1, 0, 32'h0000000A);
    issue_cmd("scroll1", 2, 0, 32'h00000020);
    do_read("scroll1_row0", 0, 0, 32'h0000000A);
    do_read("scroll1_row29_c0", 29, 0, 32'h00000020);
    do_read("scroll1_row29_c79", 29, 79, 32'h00000020);

    // Remaining scrolls until the base wraps back to 0
    for (int i = 0; i < ROWS - 1; i++) issue_cmd($sformatf("scroll%0d", i + 2), 2, 0, 32'h100 + i);
    chk("scroll_wrap_base", base_row, 32'h0);
    do_read("scroll_last_row", 29, 5, 32'h100 + ROWS - 2);
    check_screen("scroll_screen");

    // Read-before-write on the same cell
    do_write(3, 3, 32'h11);
    r_row = 5'd3;
    r_col = 7'd3;
    w_valid = 1'b1;
    w_row = 5'd3;
    w_col = 7'd3;
    w_data = 32'h22;
    tick();
    w_valid = 1'b0;
    model_write(3, 3, 32'h22);
    chk("rbw_old", r_data, 32'h11);
    tick();
    chk("rbw_new", r_data, 32'h22);

    // Write and CLEAR_ROW in the same cycle: the fill wins
    w_valid = 1'b1;
    w_row = 5'd5;
    w_col = 7'd7;
    w_data = 32'h55;
    chk("both_wready", w_ready, 1'b1);
    model_write(5, 7, 32'h55);
    issue_cmd("clear_row5", 3, 5, 32'h77);
    w_valid = 1'b0;
    do_read("clear_row5_cell", 5, 7, 32'h77);
    issue_cmd("clear_row_oob", 3, 30, 32'h99);

    // Reset in the middle of a scroll fill
    c_valid = 1'b1;
    c_cmd = 2'd2;
    c_fill = 32'h33;
    tick();
    c_valid = 1'b0;
    repeat (20) tick();
    chk("midfill_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_wready", w_ready, 1'b0);
    chk("abort_cmdready", c_ready, 1'b0);
    chk("abort_rdata", r_data, 32'h0);
    chk("abort_base", base_row, 32'h0);
    tick();
    chk("abort_hold_wready", w_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("release_wready", w_ready, 1'b1);
    base_m = 0;
    issue_cmd("resync_clear", 1, 0, 32'h0);

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      wv = $urandom_range(0, 1);
      wr = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
      wc = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 127) : $urandom_range(0, 79);
      rr = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
      rc = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 127) : $urandom_range(0, 79);
      wd = $urandom;
      cv = ($urandom_range(0, 15) == 0) ? 1 : 0;
      cmd = $urandom_range(0, 7);
      cmd = (cmd > 3) ? 2 : cmd;
      crow = $urandom_range(0, 31);
      fill = $urandom;
      w_valid = wv[0];
      w_row = 5'(wr);
      w_col = 7'(wc);
      w_data = wd;
      r_row = 5'(rr);
      r_col = 7'(rc);
      c_valid = cv[0];
      c_cmd = 2'(cmd);
      c_row = 5'(crow);
      c_fill = fill;
      exp = model_rd(rr, rc);
      tick();
      w_valid = 1'b0;
      c_valid = 1'b0;
      chk($sformatf("rand%0d_rd", it), r_data, exp);
      if (wv != 0) model_write(wr, wc, wd);
      if (cv != 0) begin
        model_cmd(cmd, crow, fill);
        wait_fill($sformatf("rand%0d_cmd%0d", it, cmd), exp_busy(cmd, crow));
      end
    end
    check_screen("rand_screen");

    // Cursor overlay
    cur_row = 5'd2;
    cur_col = 7'd3;
    r_row = 5'd2;
    r_col = 7'd3;
    tick();
`ifdef TFB_CURSOR_EN
    trans = 0;
    last_t = -1;
    prev = cur_hit;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (cur_hit !== prev) begin
        if (last_t >= 0) chk("blink_period", t - last_t, BD);
        last_t = t;
        trans++;
      end
      prev = cur_hit;
    end
    chk("blink_toggles", (trans >= 8) ? 1 : 0, 1);
    r_col = 7'd4;
    tick();
    hits = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (cur_hit !== 1'b0) hits++;
    end
    chk("curhit_other_cell", hits, 0);
`else
    hits = 0;
    trans = 0;
    last_t = 0;
    prev = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (cur_hit !== 1'b0) hits++;
    end
    chk("curhit_disabled", hits, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_frame_buffer.md
Name: text_frame_buffer

Overview:
Parametrised character-cell frame buffer between the CPU/bus write side and the text-mode display pipeline. Stores ROWS x COLS cells of CELL_W bits (attribute + glyph code), with a 1-cycle registered display read port. Adds a valid/ready write port, hardware clear-screen and scroll-up commands driven by a fill state machine, and a wrap-around base-row register, so scrolling costs COLS cycles instead of a full copy.

Parameters:
COLS, 80, cells per row
ROWS, 30, rows per screen
CELL_W, 32, bits per cell
COL_W, $clog2(COLS), column index width (derived)
ROW_W, $clog2(ROWS), row index width (derived)
BLINK_DIV, 25000000, cursor blink half-period in iClk cycles (TFB_CURSOR_EN only)

Ports:
iClk  in  1  clock; all logic is on its rising edge
iRst  in  1  asynchronous, active-high reset
iWValid  in  1  write request
oWReady  out  1  write accepted when iWValid && oWReady
iWRow  in  ROW_W  logical row of the write
iWCol  in  COL_W  column of the write
iWData  in  CELL_W  cell value
iCmdValid  in  1  command request
iCmd  in  2  0=NOP, 1=CLEAR_ALL, 2=SCROLL_UP, 3=CLEAR_ROW
iCmdRow  in  ROW_W  logical row for CLEAR_ROW
iFillData  in  CELL_W  blank-cell value, sampled on command accept
oCmdReady  out  1  command accepted when iCmdValid && oCmdReady
iRRow  in  ROW_W  display read logical row
iRCol  in  COL_W  display read column
oRData  out  CELL_W  read data, 1 cycle after address
oBusy  out  1  fill engine active
oBaseRow  out  ROW_W  current physical row shown as logical row 0
iCurRow  in  ROW_W  cursor row (TFB_CURSOR_EN)
iCurCol  in  COL_W  cursor column (TFB_CURSOR_EN)
oCurHit  out  1  cursor overlay flag, aligned with oRData

Behaviour:
- Reset (async on iRst high): state=IDLE, base=0, oRData=0, oCurHit=0, blink counter=0. oWReady, oCmdReady and oBusy are 0 while iRst is high. RAM contents are not reset.
- Address map: phys_row = (logical_row + base) mod ROWS, computed as a single conditional subtract with no divider. addr = phys_row*COLS + col.
- Out-of-range coordinates (row >= ROWS or col >= COLS):
  - write: accepted and discarded;
  - read: oRData=0.
- Read: the address sampled at edge N drives oRData after edge N. The read port is always active, including during fills. Same-cycle read and write of one cell returns the old data.
- States: IDLE, FILL.
  - oWReady = oCmdReady = (state==IDLE).
  - oBusy = (state==FILL).
- IDLE, write handshake: RAM is written the same edge, using the base in effect before that edge.
- IDLE, command handshake (iCmd != NOP): latch iFillData, then enter FILL:
  - CLEAR_ALL: base<=0; fill addr 0..ROWS*COLS-1 (ROWS*COLS cycles).
  - SCROLL_UP: fill physical row = old base (becomes logical row ROWS-1), COLS cycles; base<=base+1, wrapping ROWS-1 -> 0.
  - CLEAR_ROW: fill physical row of iCmdRow (under current base), COLS cycles. Out-of-range row: no fill, stay IDLE.
- NOP with valid is accepted with no effect.
- Write and command in the same IDLE cycle: both are accepted. The write commits first (pre-command base), and the fill may then overwrite it.
- FILL: one cell per cycle. On the last cell, return to IDLE; oWReady rises the next cycle.
- Reset during FILL aborts immediately; partially filled RAM is left as is.

Optional Feature:
TFB_CURSOR_EN.
- Defined:
  - blink counter toggles blink every BLINK_DIV cycles;
  - oCurHit = registered (iRRow==iCurRow && iCurCol==iRCol && blink), aligned with oRData.
- Undefined: cursor ports remain, inputs are ignored, oCurHit is constant 0, and no counter is built.

Decomposition:
- Package tfb_pkg: command encoding constants (TFB_CMD_NOP/CLEAR_ALL/SCROLL_UP/CLEAR_ROW), FSM state encoding, cell typedef.
- Sub-module tfb_ram: simple dual-port RAM of ROWS*COLS x CELL_W with one write port and one registered read port, read-before-write. Keeps inference portable.

Test Plan:
- Default params, reset, write (row 0, col 1, 0xFFFFFF48); read (0,1) -> oRData=0xFFFFFF48 one cycle later; read (0,80) -> 0.
- CLEAR_ALL with fill 0x00000020 -> oBusy high for exactly 2400 cycles, oWReady low throughout; every cell then reads 0x20 and oBaseRow=0.
- Write 0xA at logical (1,0), then SCROLL_UP with fill 0x20 -> oBaseRow=1, oBusy 80 cycles; logical (0,0) reads 0xA and logical (29,*) reads 0x20.
- 30 SCROLL_UPs -> oBaseRow wraps 29->0; the final row fill targets physical row 29.
- Write and CLEAR_ROW 5 in the same cycle on row 5 -> both handshakes complete and the cell reads the fill value. Assert iRst mid-fill -> outputs are 0 at once, then oWReady=1 after release.
- With TFB_CURSOR_EN and BLINK_DIV=4, cursor at (2,3):
  - reading (2,3) -> oCurHit toggles every 4 cycles;
  - reading any other cell -> oCurHit=0.
  - Without the macro, oCurHit stays 0.
